// File: rtl/corner_bbox_tracker_pkg.sv
// Shared constants, FSM encoding and bbox accumulator type for the
// corner bounding-box tracker.
package corner_bbox_tracker_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int DET_LAT_DEF  = 2;
  localparam int MIN_HITS_DEF = 4;
  localparam int CW           = 10;
  localparam int HW           = 19;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  typedef struct packed {
    logic [CW-1:0] x_min;
    logic [CW-1:0] x_max;
    logic [CW-1:0] y_min;
    logic [CW-1:0] y_max;
    logic [HW-1:0] count;
  } acc_t;

  localparam acc_t ACC_INIT = '{'1, '0, '1, '0, '0};

  function automatic acc_t acc_add(acc_t a,
                                   logic [CW-1:0] x,
                                   logic [CW-1:0] y);
    acc_t r;
    r = a;
    if (x < r.x_min) r.x_min = x;
    if (x > r.x_max) r.x_max = x;
    if (y < r.y_min) r.y_min = y;
    if (y > r.y_max) r.y_max = y;
    if (r.count != '1) r.count = r.count + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/corner_bbox_tracker_align_delay.sv
// Fixed-depth shift register that lines pixel strobes up with the
// corner flag coming out of corner_detect.
module align_delay #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/corner_bbox_tracker.sv
// Tags corner hits with raster (x,y) and reports one bounding box plus
// hit count per frame under a valid/ack handshake.
module corner_bbox_tracker
  import corner_bbox_tracker_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int DET_LATENCY = DET_LAT_DEF,
  parameter int MIN_HITS    = MIN_HITS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_valid,
  input  logic          sof,
  input  logic          corner_detected,
  input  logic          result_ack,
  output logic          result_valid,
  output logic          bbox_found,
  output logic [CW-1:0] x_min,
  output logic [CW-1:0] x_max,
  output logic [CW-1:0] y_min,
  output logic [CW-1:0] y_max,
  output logic [HW-1:0] hit_count,
  output logic          overrun
);

  localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);

  logic          dv, dsof;
  logic          start, take, last;
  logic [CW-1:0] x, y, cx, cy;
  acc_t          acc, acc_base, acc_nx;
  state_t        state, state_nx;

  align_delay #(
    .W    (2),
    .DEPTH(DET_LATENCY)
  ) u_align (
    .clk  (clk),
    .reset(reset),
    .din  ({pix_valid, sof}),
    .dout ({dv, dsof})
  );

  // A frame start always restarts at (0,0), even mid-scan.
  assign start    = dv & dsof;
  assign take     = start | (dv & (state == SCAN));
  assign cx       = start ? '0 : x;
  assign cy       = start ? '0 : y;
  assign last     = take & ~start & (cx == X_LAST) & (cy == Y_LAST);
  assign acc_base = start ? ACC_INIT : acc;
  assign acc_nx   = corner_detected ? acc_add(acc_base, cx, cy)
                                    : acc_base;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (last) state_nx = REPORT;
      REPORT:  state_nx = start ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      acc   <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        acc <= acc_nx;
        if (cx == X_LAST) begin
          x <= '0;
          y <= cy + 1'b1;
        end else begin
          x <= cx + 1'b1;
          y <= cy;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_valid <= 1'b0;
      bbox_found   <= 1'b0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      hit_count    <= '0;
      overrun      <= 1'b0;
    end else if (state == REPORT) begin
      result_valid <= 1'b1;
      if (result_valid & ~result_ack) overrun <= 1'b1;
      bbox_found <= (acc.count >= HW'(MIN_HITS));
      hit_count  <= acc.count;
      // Empty frame reports zeros rather than the init sentinels.
      if (acc.count == '0) begin
        x_min <= '0;
        x_max <= '0;
        y_min <= '0;
        y_max <= '0;
      end else begin
        x_min <= acc.x_min;
        x_max <= acc.x_max;
        y_min <= acc.y_min;
        y_max <= acc.y_max;
      end
    end else if (result_ack) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_corner_bbox_tracker.sv
// Randomized bench for corner_bbox_tracker on an 8x8 frame with a
// pixel-index reference model and a few hand-computed results.
module tb_corner_bbox_tracker;

  localparam int H  = 8;
  localparam int V  = 8;
  localparam int DL = 2;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_valid, sof, corner_detected, result_ack;
  logic       result_valid, bbox_found, overrun;
  logic [9:0] x_min, x_max, y_min, y_max;
  logic [18:0] hit_count;

  corner_bbox_tracker #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .DET_LATENCY(DL),
    .MIN_HITS   (MH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pix_valid      (pix_valid),
    .sof            (sof),
    .corner_detected(corner_detected),
    .result_ack     (result_ack),
    .result_valid   (result_valid),
    .bbox_found     (bbox_found),
    .x_min          (x_min),
    .x_max          (x_max),
    .y_min          (y_min),
    .y_max          (y_max),
    .hit_count      (hit_count),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pixel stream indexed from the last sof.
  int  mn, m_idx, m_due;
  bit  mh_pv[8], mh_sof[8];
  bit  m_act;
  int  a_cnt, a_xmin, a_xmax, a_ymin, a_ymax;
  int  f_cnt, f_xmin, f_xmax, f_ymin, f_ymax;
  bit  m_rv, m_found, m_ov;
  int  m_cnt, m_x0, m_x1, m_y0, m_y1;

  always @(posedge clk or posedge reset) begin
    int p, xx, yy;
    if (reset) begin
      mn = 0;
      for (int i = 0; i < 8; i++) begin
        mh_pv[i] = 0;
        mh_sof[i] = 0;
      end
      m_act = 0; m_due = -1; m_rv = 0; m_found = 0; m_ov = 0;
      m_cnt = 0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
    end else begin
      mn++;
      mh_pv[mn%8]  = pix_valid;
      mh_sof[mn%8] = sof;
      p = (mn + 8 - DL) % 8;
      if (m_due == mn) begin
        if (m_rv && !result_ack) m_ov = 1;
        m_rv = 1;
        m_cnt = f_cnt;
        m_found = (f_cnt >= MH);
        m_x0 = f_cnt ? f_xmin : 0;
        m_x1 = f_cnt ? f_xmax : 0;
        m_y0 = f_cnt ? f_ymin : 0;
        m_y1 = f_cnt ? f_ymax : 0;
        m_due = -1;
      end else if (result_ack) begin
        m_rv = 0;
      end
      if (mh_pv[p]) begin
        if (mh_sof[p]) begin
          m_act = 1; m_idx = 0; a_cnt = 0;
          a_xmin = 1 << 20; a_ymin = 1 << 20; a_xmax = -1; a_ymax = -1;
        end else if (m_act) begin
          m_idx++;
        end
        if (m_act) begin
          xx = m_idx % H;
          yy = m_idx / H;
          if (corner_detected) begin
            a_cnt++;
            if (xx < a_xmin) a_xmin = xx;
            if (xx > a_xmax) a_xmax = xx;
            if (yy < a_ymin) a_ymin = yy;
            if (yy > a_ymax) a_ymax = yy;
          end
          if (m_idx == H*V - 1) begin
            f_cnt = a_cnt; f_xmin = a_xmin; f_xmax = a_xmax;
            f_ymin = a_ymin; f_ymax = a_ymax;
            m_due = mn + 1;
            m_act = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("result_valid", 32'(result_valid), 32'(m_rv));
    chk("bbox_found", 32'(bbox_found), 32'(m_found));
    chk("overrun", 32'(overrun), 32'(m_ov));
    chk("hit_count", 32'(hit_count), 32'(m_cnt));
    chk("x_min", 32'(x_min), 32'(m_x0));
    chk("x_max", 32'(x_max), 32'(m_x1));
    chk("y_min", 32'(y_min), 32'(m_y0));
    chk("y_max", 32'(y_max), 32'(m_y1));
  end

  // Stimulus: flags are scheduled DL (+late) slots after their pixel.
  int         slot_no = 0;
  int         force_ack_slot = -1;
  bit         noise_en = 0;
  bit         ack_rand = 0;
  logic [15:0] fut_hit = '0;
  logic [15:0] fut_dv = '0;

  task automatic step(input bit pv, input bit sf, input bit h,
                      input int late);
    corner_detected = fut_hit[0] |
                      (noise_en & ~fut_dv[0] & 1'($urandom % 2));
    fut_hit = fut_hit >> 1;
    fut_dv  = fut_dv >> 1;
    if (pv) begin
      fut_dv[DL-1] = 1'b1;
      if (h) fut_hit[DL-1+late] = 1'b1;
    end
    pix_valid  = pv;
    sof        = sf;
    result_ack = (slot_no == force_ack_slot) |
                 (ack_rand & ($urandom % 4 == 0));
    @(posedge clk);
    #1;
    slot_no++;
  endtask

  task automatic drive(input int npix, input logic [63:0] hits,
                       input int gap_pct, input int late,
                       output int last_slot);
    for (int i = 0; i < npix; i++) begin
      if (i > 0)
        while ($urandom_range(99) < gap_pct) step(0, 0, 0, 0);
      last_slot = slot_no;
      step(1, i == 0, hits[i], late);
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++)
      step(noise_en && ($urandom % 5 == 0), 0, 0, 0);
  endtask

  task automatic ack_now();
    force_ack_slot = slot_no;
    blank(2);
  endtask

  int ls;
  logic [63:0] rh;

  initial begin
    reset = 1'b1;
    pix_valid = 0; sof = 0; corner_detected = 0; result_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst result_valid", 32'(result_valid), 0);
    chk("rst hit_count", 32'(hit_count), 0);
    chk("rst overrun", 32'(overrun), 0);
    reset = 1'b0;

    // Single hit at (5,7)
    drive(64, 64'd1 << 61, 0, 0, ls);
    blank(6);
    chk("t1 x_min", 32'(x_min), 5);
    chk("t1 x_max", 32'(x_max), 5);
    chk("t1 y_min", 32'(y_min), 7);
    chk("t1 y_max", 32'(y_max), 7);
    chk("t1 count", 32'(hit_count), 1);
    chk("t1 found", 32'(bbox_found), 0);
    ack_now();
    chk("t1 acked", 32'(result_valid), 0);

    // (1,1),(6,2),(3,6),(2,4)
    rh = '0;
    rh[9] = 1; rh[22] = 1; rh[51] = 1; rh[34] = 1;
    drive(64, rh, 0, 0, ls);
    blank(6);
    chk("t2 x_min", 32'(x_min), 1);
    chk("t2 x_max", 32'(x_max), 6);
    chk("t2 y_min", 32'(y_min), 1);
    chk("t2 y_max", 32'(y_max), 6);
    chk("t2 count", 32'(hit_count), 4);
    chk("t2 found", 32'(bbox_found), 1);
    ack_now();

    // Flag alignment: on time -> (0,0); one clock late -> (1,0)
    drive(64, 64'd1, 0, 0, ls);
    blank(6);
    chk("t3 x_min", 32'(x_min), 0);
    chk("t3 y_min", 32'(y_min), 0);
    ack_now();
    drive(64, 64'd1, 0, 1, ls);
    blank(6);
    chk("t3 late x_min", 32'(x_min), 1);
    chk("t3 late y_min", 32'(y_min), 0);
    chk("t3 late count", 32'(hit_count), 1);

    // Ack coincides with REPORT of the next frame
    drive(64, (64'd1 << 63) | 64'd1, 0, 0, ls);
    force_ack_slot = ls + 3;
    blank(6);
    chk("t4 valid", 32'(result_valid), 1);
    chk("t4 overrun", 32'(overrun), 0);
    chk("t4 count", 32'(hit_count), 2);
    chk("t4 x_max", 32'(x_max), 7);

    // No ack: second unacked frame sets overrun
    rh = '0;
    rh[10] = 1; rh[20] = 1; rh[30] = 1;
    drive(64, rh, 0, 0, ls);
    blank(6);
    chk("t5 overrun", 32'(overrun), 1);
    chk("t5 count", 32'(hit_count), 3);
    chk("t5 y_max", 32'(y_max), 3);

    // Reset mid-scan clears outputs immediately
    drive(30, '1, 0, 0, ls);
    reset = 1'b1;
    #1;
    chk("t6 valid", 32'(result_valid), 0);
    chk("t6 overrun", 32'(overrun), 0);
    chk("t6 count", 32'(hit_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    fut_hit = '0;
    fut_dv = '0;
    blank(4);

    // Short frame: sof at pixel 20, then full frame
    drive(20, '1, 0, 0, ls);
    drive(64, 64'd1 << 12, 0, 0, ls);
    blank(6);
    chk("t7 count", 32'(hit_count), 1);
    chk("t7 x_min", 32'(x_min), 4);
    chk("t7 y_min", 32'(y_min), 1);
    ack_now();

    // Randomized frames
    noise_en = 1;
    ack_rand = 1;
    for (int f = 0; f < 40; f++) begin
      case ($urandom % 4)
        0:       rh = '0;
        1:       rh = {$urandom, $urandom} & {$urandom, $urandom};
        2:       rh = 64'd1 << $urandom_range(63);
        default: rh = {$urandom, $urandom};
      endcase
      if ($urandom % 5 == 0)
        drive($urandom_range(1, 63), {$urandom, $urandom}, 20, 0, ls);
      drive(64, rh, 20, 0, ls);
      blank($urandom_range(3, 8));
    end
    blank(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
